// File: rtl/tlc5955_ctrl_loader_if.sv
// Handshake and serial-pin bundle for the TLC5955 control-latch loader.
// The loader drives the shared SCLK/SDO/LAT pins plus busy/initDone; the requester drives req.
interface tlc5955_ctrl_loader_if;
    logic req;
    logic SCLK;
    logic SDO;
    logic LAT;
    logic busy;
    logic initDone;

    modport master (
        output req,
        input  SCLK,
        input  SDO,
        input  LAT,
        input  busy,
        input  initDone
    );

    modport slave (
        input  req,
        output SCLK,
        output SDO,
        output LAT,
        output busy,
        output initDone
    );
endinterface

// File: rtl/tlc5955_ctrl_loader.sv
// Loads the TLC5955 control latch (FC/BC/MC/DC) into a daisy chain, PASSES times per request.
// Optional macro TLC5955_DC_PER_CH_EN replaces the global dc input with a writable 48x7 DC table.
module tlc5955_ctrl_loader #(
    parameter int NUM_TLC5955 = 1,
    parameter int PASSES      = 2,
    parameter int AUTO_INIT   = 1
) (
    input  logic                  spiClk,
    input  logic                  nReset,
    tlc5955_ctrl_loader_if.slave  bus,
    input  logic [4:0]            fc,
    input  logic [6:0]            bc_r,
    input  logic [6:0]            bc_g,
    input  logic [6:0]            bc_b,
    input  logic [8:0]            mc,
    input  logic [6:0]            dc
`ifdef TLC5955_DC_PER_CH_EN
    ,
    input  logic                  dc_we,
    input  logic [5:0]            dc_addr,
    input  logic [6:0]            dc_wdata
`endif
);

    localparam int FRAME_BITS = 769;
    localparam int DC_BITS    = 336;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DEV_W      = (NUM_TLC5955 > 1) ? $clog2(NUM_TLC5955) : 1;
    localparam int PASS_W     = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [DEV_W-1:0]  DEV_LAST  = DEV_W'(NUM_TLC5955 - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SH_LO = 3'd2,
        ST_SH_HI = 3'd3,
        ST_LATCH = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Frame bit at index idx (768 = first bit on the wire); the frame is never stored.
    function automatic logic frame_bit(
        input logic [BIT_W-1:0]   idx,
        input logic [4:0]         f,
        input logic [20:0]        bc,
        input logic [8:0]         m,
        input logic [DC_BITS-1:0] d
    );
        logic [FRAME_BITS-1:0] frame;
        frame = {1'b1, 8'h96, 389'd0, f, bc, m, d};
        return frame[idx];
    endfunction

    state_t              state_r, state_nx;
    logic [BIT_W-1:0]    bit_cnt_r, bit_cnt_nx;
    logic [DEV_W-1:0]    dev_cnt_r, dev_cnt_nx;
    logic [PASS_W-1:0]   pass_cnt_r, pass_cnt_nx;
    logic                lat_cnt_r, lat_cnt_nx;
    logic                auto_pend_r;
    logic                accept_s;

    logic [4:0]          fc_snap_r;
    logic [20:0]         bc_snap_r;
    logic [8:0]          mc_snap_r;
    logic [DC_BITS-1:0]  dc_snap_r;
    logic [DC_BITS-1:0]  dc_src_s;
    logic                frame_bit_s;

    logic                sclk_r;
    logic                sdo_r;
    logic                lat_r;
    logic                busy_r;
    logic                init_done_r;

`ifdef TLC5955_DC_PER_CH_EN
    logic [DC_BITS-1:0]  dc_tab_r;
    logic [8:0]          dc_base_s;
    logic                unused_dc_s;

    assign dc_base_s   = {3'b000, dc_addr} * 9'd7;
    assign unused_dc_s = ^dc;
    assign dc_src_s    = dc_tab_r;

    // Per-channel DC table; channel k lives at bits [7k+6:7k], out-of-range addresses dropped.
    always_ff @(posedge spiClk) begin
        if (!nReset) begin
            dc_tab_r <= {48{7'd127}};
        end else if (dc_we && (dc_addr < 6'd48)) begin
            dc_tab_r[dc_base_s +: 7] <= dc_wdata;
        end
    end
`else
    assign dc_src_s = {48{dc}};
`endif

    // State, counters and the pending auto-init request.
    always_ff @(posedge spiClk) begin
        if (!nReset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {BIT_W{1'b0}};
            dev_cnt_r   <= {DEV_W{1'b0}};
            pass_cnt_r  <= {PASS_W{1'b0}};
            lat_cnt_r   <= 1'b0;
            auto_pend_r <= (AUTO_INIT != 0);
        end else begin
            state_r     <= state_nx;
            bit_cnt_r   <= bit_cnt_nx;
            dev_cnt_r   <= dev_cnt_nx;
            pass_cnt_r  <= pass_cnt_nx;
            lat_cnt_r   <= lat_cnt_nx;
            auto_pend_r <= auto_pend_r & ~accept_s;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_nx    = state_r;
        bit_cnt_nx  = bit_cnt_r;
        dev_cnt_nx  = dev_cnt_r;
        pass_cnt_nx = pass_cnt_r;
        lat_cnt_nx  = lat_cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.req || auto_pend_r) begin
                    accept_s    = 1'b1;
                    pass_cnt_nx = {PASS_W{1'b0}};
                    state_nx    = ST_LOAD;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_LOAD: begin
                bit_cnt_nx = {BIT_W{1'b0}};
                dev_cnt_nx = {DEV_W{1'b0}};
                state_nx   = ST_SH_LO;
            end
            ST_SH_LO: begin
                state_nx = ST_SH_HI;
            end
            ST_SH_HI: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_nx = {BIT_W{1'b0}};
                    if (dev_cnt_r == DEV_LAST) begin
                        lat_cnt_nx = 1'b0;
                        state_nx   = ST_LATCH;
                    end else begin
                        dev_cnt_nx = dev_cnt_r + {{(DEV_W-1){1'b0}}, 1'b1};
                        state_nx   = ST_SH_LO;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
                    state_nx   = ST_SH_LO;
                end
            end
            ST_LATCH: begin
                // Two LAT cycles keep the strobe >= 30 ns up to 66 MHz.
                if (lat_cnt_r) begin
                    state_nx = ST_GAP;
                end else begin
                    lat_cnt_nx = 1'b1;
                    state_nx   = ST_LATCH;
                end
            end
            ST_GAP: begin
                if (pass_cnt_r == PASS_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    pass_cnt_nx = pass_cnt_r + {{(PASS_W-1){1'b0}}, 1'b1};
                    state_nx    = ST_LOAD;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Config snapshot, frozen for the whole request once accepted.
    always_ff @(posedge spiClk) begin
        if (!nReset) begin
            fc_snap_r <= 5'd0;
            bc_snap_r <= 21'd0;
            mc_snap_r <= 9'd0;
            dc_snap_r <= {DC_BITS{1'b0}};
        end else if (accept_s) begin
            fc_snap_r <= fc;
            bc_snap_r <= {bc_b, bc_g, bc_r};
            mc_snap_r <= mc;
            dc_snap_r <= dc_src_s;
        end
    end

    // Bit for the upcoming SH_LO phase, using the counter value that phase will see.
    assign frame_bit_s = frame_bit(BIT_LAST - bit_cnt_nx, fc_snap_r, bc_snap_r, mc_snap_r, dc_snap_r);

    // Pin and status registers, decoded from the next state so they line up with it.
    always_ff @(posedge spiClk) begin
        if (!nReset) begin
            sclk_r      <= 1'b0;
            sdo_r       <= 1'b0;
            lat_r       <= 1'b0;
            busy_r      <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            sclk_r      <= (state_nx == ST_SH_HI);
            lat_r       <= (state_nx == ST_LATCH);
            busy_r      <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
            init_done_r <= init_done_r | (state_nx == ST_DONE);
            case (state_nx)
                ST_SH_LO: sdo_r <= frame_bit_s;
                ST_SH_HI: sdo_r <= sdo_r;
                default:  sdo_r <= 1'b0;
            endcase
        end
    end

    assign bus.SCLK     = sclk_r;
    assign bus.SDO      = sdo_r;
    assign bus.LAT      = lat_r;
    assign bus.busy     = busy_r;
    assign bus.initDone = init_done_r;

endmodule

// File: tb/tb_tlc5955_ctrl_loader.sv
// Self-checking bench for tlc5955_ctrl_loader: one N=1/PASSES=2/AUTO_INIT instance, one N=3 manual instance.
// Expected bit streams come from a field-by-field frame model built in queues.
module tb_tlc5955_ctrl_loader;
    logic spiClk = 1'b0;
    logic nReset = 1'b0;
    logic [4:0] fc_v  = 5'd0;
    logic [6:0] bcr_v = 7'd0, bcg_v = 7'd0, bcb_v = 7'd0, dc_v = 7'd0;
    logic [8:0] mc_v  = 9'd0;
`ifdef TLC5955_DC_PER_CH_EN
    logic       dc_we_v    = 1'b0;
    logic [5:0] dc_addr_v  = 6'd0;
    logic [6:0] dc_wdata_v = 7'd0;
    int         exp_tab[48];
`endif

    tlc5955_ctrl_loader_if b1();
    tlc5955_ctrl_loader_if b3();

    tlc5955_ctrl_loader #(.NUM_TLC5955(1), .PASSES(2), .AUTO_INIT(1)) dut1 (
        .spiClk(spiClk), .nReset(nReset), .bus(b1.slave),
        .fc(fc_v), .bc_r(bcr_v), .bc_g(bcg_v), .bc_b(bcb_v), .mc(mc_v), .dc(dc_v)
`ifdef TLC5955_DC_PER_CH_EN
        , .dc_we(dc_we_v), .dc_addr(dc_addr_v), .dc_wdata(dc_wdata_v)
`endif
    );

    tlc5955_ctrl_loader #(.NUM_TLC5955(3), .PASSES(2), .AUTO_INIT(0)) dut3 (
        .spiClk(spiClk), .nReset(nReset), .bus(b3.slave),
        .fc(fc_v), .bc_r(bcr_v), .bc_g(bcg_v), .bc_b(bcb_v), .mc(mc_v), .dc(dc_v)
`ifdef TLC5955_DC_PER_CH_EN
        , .dc_we(dc_we_v), .dc_addr(dc_addr_v), .dc_wdata(dc_wdata_v)
`endif
    );

    always #5 spiClk = ~spiClk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] s_fc;
    logic [6:0] s_bcr, s_bcg, s_bcb, s_dc;
    logic [8:0] s_mc;

    logic cap_q[$];
    logic exp_q[$];
    int   lat_w_q[$];
    int   lat_pos_q[$];
    int   busy_cyc;
    bit   timed_out;
    bit   init_dropped;

    task automatic randomize_cfg();
        fc_v  = 5'($urandom);
        bcr_v = 7'($urandom);
        bcg_v = 7'($urandom);
        bcb_v = 7'($urandom);
        mc_v  = 9'($urandom);
        dc_v  = 7'($urandom);
    endtask

    task automatic take_snapshot();
        s_fc = fc_v; s_bcr = bcr_v; s_bcg = bcg_v; s_bcb = bcb_v; s_mc = mc_v; s_dc = dc_v;
    endtask

    task automatic reset_table_model();
`ifdef TLC5955_DC_PER_CH_EN
        for (int k = 0; k < 48; k++) exp_tab[k] = 127;
`endif
    endtask

    // Reference: one frame listed field by field in wire order, repeated per device and pass.
    task automatic make_expected(input int ndev, input int npass);
        logic fr[$];
        logic [7:0] hdr;
        logic [6:0] dcv;
        fr = {};
        hdr = 8'h96;
        fr.push_back(1'b1);
        for (int i = 7; i >= 0; i--) fr.push_back(hdr[i]);
        repeat (389) fr.push_back(1'b0);
        for (int i = 4; i >= 0; i--) fr.push_back(s_fc[i]);
        for (int i = 6; i >= 0; i--) fr.push_back(s_bcb[i]);
        for (int i = 6; i >= 0; i--) fr.push_back(s_bcg[i]);
        for (int i = 6; i >= 0; i--) fr.push_back(s_bcr[i]);
        for (int i = 8; i >= 0; i--) fr.push_back(s_mc[i]);
        for (int ch = 47; ch >= 0; ch--) begin
`ifdef TLC5955_DC_PER_CH_EN
            dcv = 7'(exp_tab[ch]);
`else
            dcv = s_dc;
`endif
            for (int i = 6; i >= 0; i--) fr.push_back(dcv[i]);
        end
        exp_q = {};
        repeat (ndev * npass) foreach (fr[k]) exp_q.push_back(fr[k]);
    endtask

    task automatic set_req(input int sel, input logic v);
        if (sel == 0) b1.req = v;
        else          b3.req = v;
    endtask

    task automatic pulse_req(input int sel);
        @(negedge spiClk);
        take_snapshot();
        set_req(sel, 1'b1);
        @(posedge spiClk);
        #1;
        set_req(sel, 1'b0);
    endtask

    // Watches one instance until busy falls, recording SDO on each SCLK-high cycle and LAT pulses.
    task automatic collect(input int sel, input int max_cyc, input bit toggle, input int poke_at);
        logic s, d, l, b, i;
        bit   seen_busy, done;
        int   lat_run;
        cap_q = {}; lat_w_q = {}; lat_pos_q = {};
        busy_cyc = 0; seen_busy = 0; done = 0; lat_run = 0; init_dropped = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge spiClk);
            if (sel == 0) begin s = b1.SCLK; d = b1.SDO; l = b1.LAT; b = b1.busy; i = b1.initDone; end
            else          begin s = b3.SCLK; d = b3.SDO; l = b3.LAT; b = b3.busy; i = b3.initDone; end
            if (!i) init_dropped = 1;
            if (b) begin seen_busy = 1; busy_cyc++; end
            if (s) cap_q.push_back(d);
            if (l) begin
                if (lat_run == 0) lat_pos_q.push_back(cap_q.size());
                lat_run++;
            end else if (lat_run != 0) begin
                lat_w_q.push_back(lat_run);
                lat_run = 0;
            end
            if (toggle) randomize_cfg();
            if (c == poke_at)     set_req(sel, 1'b1);
            if (c == poke_at + 1) set_req(sel, 1'b0);
            if (seen_busy && !b) begin done = 1; break; end
        end
        timed_out = !done;
    endtask

    task automatic check_stream(input string name);
        int errs, first;
        errs = 0; first = -1;
        if (cap_q.size() == exp_q.size()) begin
            foreach (exp_q[k]) if (cap_q[k] !== exp_q[k]) begin errs++; if (first < 0) first = k; end
        end
        n_checks++;
        if (timed_out || cap_q.size() != exp_q.size() || errs != 0) begin
            n_fail++;
            $display("FAIL %s: timeout=%0d bits=%0d wrong=%0d first_bad=%0d, required timeout=0 bits=%0d wrong=0",
                     name, timed_out, cap_q.size(), errs, first, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_table_model();
        nReset = 1'b0;
        b1.req = 1'b0; b3.req = 1'b0;
        repeat (3) @(negedge spiClk);
        n_checks++;
        if ({b1.SCLK, b1.SDO, b1.LAT, b1.busy, b1.initDone} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_dut1: {SCLK,SDO,LAT,busy,initDone}=%b required 00000",
                     {b1.SCLK, b1.SDO, b1.LAT, b1.busy, b1.initDone});
        end
        n_checks++;
        if ({b3.SCLK, b3.SDO, b3.LAT, b3.busy, b3.initDone} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_dut3: {SCLK,SDO,LAT,busy,initDone}=%b required 00000",
                     {b3.SCLK, b3.SDO, b3.LAT, b3.busy, b3.initDone});
        end
    endtask

    task automatic test_auto_init();
        logic [8:0] hdr;
        int nz;
        randomize_cfg();
        take_snapshot();
        make_expected(1, 2);
        nReset = 1'b1;
        collect(0, 4000, 1'b0, -1);
        check_stream("auto_stream");
        hdr = 9'd0; nz = 0;
        if (cap_q.size() >= 398) begin
            for (int k = 0; k < 9; k++) hdr = {hdr[7:0], cap_q[k]};
            for (int k = 9; k < 398; k++) if (cap_q[k] === 1'b0) nz++;
        end
        n_checks++;
        if (hdr !== 9'h196 || nz != 389) begin
            n_fail++;
            $display("FAIL auto_header: header=%h zeros=%0d, required header=196 zeros=389", hdr, nz);
        end
        n_checks++;
        if (lat_w_q.size() != 2 || lat_w_q[0] != 2 || lat_w_q[1] != 2 || lat_pos_q[0] != 769 || lat_pos_q[1] != 1538) begin
            n_fail++;
            $display("FAIL auto_lat: pulses=%0d widths=%p positions=%p, required 2 pulses width 2 at 769,1538",
                     lat_w_q.size(), lat_w_q, lat_pos_q);
        end
        n_checks++;
        if (busy_cyc != 2 * (4 + 1538)) begin
            n_fail++;
            $display("FAIL auto_busy_len: %0d cycles, required %0d", busy_cyc, 2 * (4 + 1538));
        end
        n_checks++;
        if (b1.initDone !== 1'b1 || b1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_done: initDone=%b busy=%b, required 1 0", b1.initDone, b1.busy);
        end
    endtask

    task automatic test_chain3();
        fc_v = 5'b01111; bcb_v = 7'd127; bcg_v = 7'd51; bcr_v = 7'd127; mc_v = 9'o111; dc_v = 7'd127;
        pulse_req(1);
        make_expected(3, 2);
        collect(1, 12000, 1'b0, -1);
        check_stream("chain3_stream");
        n_checks++;
        if (lat_w_q.size() != 2 || lat_pos_q[0] != 2307 || lat_pos_q[1] != 4614 || lat_w_q[0] != 2 || lat_w_q[1] != 2) begin
            n_fail++;
            $display("FAIL chain3_lat: widths=%p positions=%p, required two width-2 pulses at 2307,4614",
                     lat_w_q, lat_pos_q);
        end
        n_checks++;
        if (busy_cyc != 2 * (4 + 1538 * 3)) begin
            n_fail++;
            $display("FAIL chain3_busy_len: %0d cycles, required %0d", busy_cyc, 2 * (4 + 1538 * 3));
        end
    endtask

    task automatic test_snapshot_toggle();
        randomize_cfg();
        pulse_req(0);
        make_expected(1, 2);
        collect(0, 4000, 1'b1, -1);
        check_stream("snapshot_stream");
    endtask

    task automatic test_back_to_back();
        randomize_cfg();
        pulse_req(0);
        make_expected(1, 2);
        collect(0, 4000, 1'b0, 500);
        check_stream("midreq_stream");
        n_checks++;
        if (busy_cyc != 2 * (4 + 1538) || lat_w_q.size() != 2) begin
            n_fail++;
            $display("FAIL midreq_ignored: busy=%0d lat_pulses=%0d, required busy=%0d lat_pulses=2",
                     busy_cyc, lat_w_q.size(), 2 * (4 + 1538));
        end
        randomize_cfg();
        pulse_req(0);
        make_expected(1, 2);
        collect(0, 4000, 1'b0, -1);
        check_stream("done_req_stream");
        n_checks++;
        if (init_dropped || b1.initDone !== 1'b1) begin
            n_fail++;
            $display("FAIL done_req_initdone: dropped=%0d final=%b, required dropped=0 final=1",
                     init_dropped, b1.initDone);
        end
    endtask

    task automatic test_reset_mid();
        int  nbits;
        bit  lat_seen, reached;
        randomize_cfg();
        pulse_req(0);
        nbits = 0; lat_seen = 0; reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge spiClk);
            if (b1.LAT) lat_seen = 1;
            if (b1.SCLK) nbits++;
            if (nbits == 400) begin reached = 1; nReset = 1'b0; break; end
        end
        @(negedge spiClk);
        n_checks++;
        if (!reached || lat_seen || {b1.SCLK, b1.SDO, b1.LAT, b1.busy, b1.initDone} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid: reached=%0d lat_seen=%0d outputs=%b, required 1 0 00000",
                     reached, lat_seen, {b1.SCLK, b1.SDO, b1.LAT, b1.busy, b1.initDone});
        end
        reset_table_model();
        nReset = 1'b1;
        make_expected(1, 2);
        collect(0, 4000, 1'b0, -1);
        check_stream("reset_restart_stream");
    endtask

`ifdef TLC5955_DC_PER_CH_EN
    task automatic test_dc_table();
        logic [6:0] f0, f47;
        @(negedge spiClk); dc_we_v = 1'b1; dc_addr_v = 6'd0;  dc_wdata_v = 7'd5;
        @(negedge spiClk); dc_addr_v = 6'd47; dc_wdata_v = 7'd100;
        @(negedge spiClk); dc_addr_v = 6'd50; dc_wdata_v = 7'd33;
        @(negedge spiClk); dc_we_v = 1'b0;
        exp_tab[0] = 5; exp_tab[47] = 100;
        pulse_req(0);
        make_expected(1, 2);
        collect(0, 4000, 1'b0, -1);
        check_stream("dc_table_stream");
        f0 = 7'd0; f47 = 7'd0;
        if (cap_q.size() >= 769) begin
            for (int k = 762; k <= 768; k++) f0  = {f0[5:0], cap_q[k]};
            for (int k = 433; k <= 439; k++) f47 = {f47[5:0], cap_q[k]};
        end
        n_checks++;
        if (f0 !== 7'd5 || f47 !== 7'd100) begin
            n_fail++;
            $display("FAIL dc_table_fields: ch0=%0d ch47=%0d, required 5 100", f0, f47);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_auto_init();
        test_chain3();
        test_snapshot_toggle();
        test_back_to_back();
        test_reset_mid();
`ifdef TLC5955_DC_PER_CH_EN
        test_dc_table();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
